// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit and the decoder.
// Holds the ARM condition-code enum and the bit positions of each status flag.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_t;

    // Bit positions inside the 5-bit {Q,N,Z,C,V} status word. The low four
    // indices also apply to a bare 4-bit {N,Z,C,V} vector.
    localparam int FLG_Q = 4;
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether a 4-bit ARM condition
// code passes against a {N,Z,C,V} flag vector. Shared with the decoder.
module cond_check (
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);
    import cond_pkg::*;

    logic n_flag;
    logic z_flag;
    logic c_flag;
    logic v_flag;

    assign n_flag = nzcv[FLG_N];
    assign z_flag = nzcv[FLG_Z];
    assign c_flag = nzcv[FLG_C];
    assign v_flag = nzcv[FLG_V];

    // Map each condition code onto its flag expression; NV never passes.
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z_flag;
            COND_NE: pass = ~z_flag;
            COND_CS: pass = c_flag;
            COND_CC: pass = ~c_flag;
            COND_MI: pass = n_flag;
            COND_PL: pass = ~n_flag;
            COND_VS: pass = v_flag;
            COND_VC: pass = ~v_flag;
            COND_HI: pass = c_flag & ~z_flag;
            COND_LS: pass = ~c_flag | z_flag;
            COND_GE: pass = (n_flag == v_flag);
            COND_LT: pass = (n_flag != v_flag);
            COND_GT: pass = ~z_flag & (n_flag == v_flag);
            COND_LE: pass = z_flag | (n_flag != v_flag);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: owns the {Q,N,Z,C,V} status register, gates the
// decoder's write/branch requests with the evaluated condition, and counts
// executed and skipped instructions for debug.
// Optional feature macro: COND_STICKY_Q_EN enables the sticky-overflow Q bit;
// without it flags[4] is held at 0 and q_clear is ignored.
module cond_logic #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_write,
    input  logic             pc_s,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             no_write,
    input  logic             q_clear,
    output logic [4:0]       flags,
    output logic             cond_ex,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_write,
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] skip_count
);
    import cond_pkg::*;

    logic [4:0]       flags_q;
    logic [4:0]       flags_d;
    logic [CNT_W-1:0] exec_count_q;
    logic [CNT_W-1:0] exec_count_d;
    logic [CNT_W-1:0] skip_count_q;
    logic [CNT_W-1:0] skip_count_d;
    logic             cond_pass;

    // Conditions are always judged against the registered flags, so an
    // instruction that also writes flags sees the old values.
    cond_check u_cond_check (
        .cond (cond),
        .nzcv (flags_q[3:0]),
        .pass (cond_pass)
    );

    assign cond_ex    = instr_valid & cond_pass;
    assign pc_src     = pc_s & cond_ex;
    assign reg_write  = reg_w & cond_ex & ~no_write;
    assign mem_write  = mem_w & cond_ex;
    assign flags      = flags_q;
    assign exec_count = exec_count_q;
    assign skip_count = skip_count_q;

`ifndef COND_STICKY_Q_EN
    logic unused_q_clear;
    assign unused_q_clear = q_clear;
`endif

    // Next flag value: N,Z and C,V load independently; Q is sticky when enabled.
    always_comb begin
        flags_d = flags_q;
        if (cond_ex & flag_write[1]) begin
            flags_d[FLG_N] = alu_flags[3];
            flags_d[FLG_Z] = alu_flags[2];
        end
        if (cond_ex & flag_write[0]) begin
            flags_d[FLG_C] = alu_flags[1];
            flags_d[FLG_V] = alu_flags[0];
        end
`ifdef COND_STICKY_Q_EN
        if (cond_ex & flag_write[0] & alu_flags[0]) begin
            flags_d[FLG_Q] = 1'b1;
        end else if (instr_valid & q_clear) begin
            flags_d[FLG_Q] = 1'b0;
        end
`else
        flags_d[FLG_Q] = 1'b0;
`endif
    end

    // Next counter values: each valid instruction bumps exactly one counter.
    always_comb begin
        exec_count_d = exec_count_q;
        skip_count_d = skip_count_q;
        if (instr_valid) begin
            if (cond_ex) begin
                exec_count_d = exec_count_q + CNT_W'(1);
            end else begin
                skip_count_d = skip_count_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset overrides any update in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q      <= 5'b0;
            exec_count_q <= '0;
            skip_count_q <= '0;
        end else begin
            flags_q      <= flags_d;
            exec_count_q <= exec_count_d;
            skip_count_q <= skip_count_d;
        end
    end

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic with a reference model and a scoreboard
// of expected snapshots. Honours COND_STICKY_Q_EN when it is defined.
module tb_cond_logic;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             instr_valid;
    logic [3:0]       cond;
    logic [3:0]       alu_flags;
    logic [1:0]       flag_write;
    logic             pc_s;
    logic             reg_w;
    logic             mem_w;
    logic             no_write;
    logic             q_clear;
    logic [4:0]       flags;
    logic             cond_ex;
    logic             pc_src;
    logic             reg_write;
    logic             mem_write;
    logic [CNT_W-1:0] exec_count;
    logic [CNT_W-1:0] skip_count;

    cond_logic #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .cond        (cond),
        .alu_flags   (alu_flags),
        .flag_write  (flag_write),
        .pc_s        (pc_s),
        .reg_w       (reg_w),
        .mem_w       (mem_w),
        .no_write    (no_write),
        .q_clear     (q_clear),
        .flags       (flags),
        .cond_ex     (cond_ex),
        .pc_src      (pc_src),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .exec_count  (exec_count),
        .skip_count  (skip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       r;
        logic       v;
        logic [3:0] c;
        logic [3:0] a;
        logic [1:0] fw;
        logic       ps;
        logic       rw;
        logic       mw;
        logic       nw;
        logic       qc;
    } stim_t;

    typedef struct packed {
        logic             cond_ex;
        logic             pc_src;
        logic             reg_write;
        logic             mem_write;
        logic [4:0]       flags;
        logic [CNT_W-1:0] exec;
        logic [CNT_W-1:0] skip;
    } snap_t;

    snap_t            sb_q[$];
    int               checks;
    int               errors;
    logic [4:0]       m_flags;
    logic [CNT_W-1:0] m_exec;
    logic [CNT_W-1:0] m_skip;

`ifdef COND_STICKY_Q_EN
    localparam logic Q_ON = 1'b1;
`else
    localparam logic Q_ON = 1'b0;
`endif

    function automatic stim_t mk(input logic r, input logic v, input logic [3:0] c,
                                 input logic [3:0] a, input logic [1:0] fw,
                                 input logic ps, input logic rw, input logic mw,
                                 input logic nw, input logic qc);
        stim_t s;
        s.r = r; s.v = v; s.c = c; s.a = a; s.fw = fw;
        s.ps = ps; s.rw = rw; s.mw = mw; s.nw = nw; s.qc = qc;
        return s;
    endfunction

    // Reference condition table written straight from the ARM definitions.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one cycle, push the model's expectation, sample the DUT and pop.
    task automatic step(input stim_t s, output snap_t obs, output snap_t expv, output bit have);
        snap_t e;
        logic  pass;
        logic [4:0] nf;
        rst = s.r; instr_valid = s.v; cond = s.c; alu_flags = s.a; flag_write = s.fw;
        pc_s = s.ps; reg_w = s.rw; mem_w = s.mw; no_write = s.nw; q_clear = s.qc;
        pass = s.v & ref_pass(s.c, m_flags[3:0]);
        e.cond_ex   = pass;
        e.pc_src    = s.ps & pass;
        e.reg_write = s.rw & pass & ~s.nw;
        e.mem_write = s.mw & pass;
        nf = m_flags;
        if (pass && s.fw[1]) nf[3:2] = s.a[3:2];
        if (pass && s.fw[0]) nf[1:0] = s.a[1:0];
        if (Q_ON) begin
            if (pass && s.fw[0] && s.a[0]) nf[4] = 1'b1;
            else if (s.v && s.qc)          nf[4] = 1'b0;
        end else begin
            nf[4] = 1'b0;
        end
        if (s.r) begin
            m_flags = 5'b0; m_exec = '0; m_skip = '0;
        end else begin
            m_flags = nf;
            if (s.v && pass)  m_exec = m_exec + 1'b1;
            if (s.v && !pass) m_skip = m_skip + 1'b1;
        end
        e.flags = m_flags; e.exec = m_exec; e.skip = m_skip;
        sb_q.push_back(e);
        #2;
        obs.cond_ex = cond_ex; obs.pc_src = pc_src;
        obs.reg_write = reg_write; obs.mem_write = mem_write;
        @(posedge clk);
        #1;
        obs.flags = flags; obs.exec = exec_count; obs.skip = skip_count;
        have = (sb_q.size() > 0);
        expv = have ? sb_q.pop_front() : '0;
    endtask

    task automatic test_reset();
        snap_t o, e; bit h;
        step(mk(1,1,4'd14,4'b1111,2'b11,1,1,1,0,0), o, e, h);
        checks++;
        if (!h || o !== e) begin errors++; $display("[TB] FAIL reset got %h want %h", o, e); end
        checks++;
        if (o.flags !== 5'b0 || o.exec !== '0 || o.skip !== '0) begin
            errors++; $display("[TB] FAIL reset_state got %h want zero", {o.flags, o.exec, o.skip});
        end
        step(mk(0,1,4'd0,4'b0000,2'b00,1,0,0,0,0), o, e, h);
        checks++;
        if (!h || o !== e || o.cond_ex !== 1'b0) begin errors++; $display("[TB] FAIL eq_after_reset got %h want %h", o, e); end
        step(mk(0,1,4'd1,4'b0000,2'b00,1,0,0,0,0), o, e, h);
        checks++;
        if (!h || o !== e || o.cond_ex !== 1'b1) begin errors++; $display("[TB] FAIL ne_after_reset got %h want %h", o, e); end
    endtask

    task automatic test_al_write();
        snap_t o, e; bit h;
        step(mk(1,0,4'd0,4'b0,2'b00,0,0,0,0,0), o, e, h);
        step(mk(0,1,4'd14,4'b0,2'b00,0,1,0,0,0), o, e, h);
        checks++;
        if (!h || o !== e || o.reg_write !== 1'b1 || o.exec !== 4'd1 || o.flags !== 5'b0) begin
            errors++; $display("[TB] FAIL al_reg_write got %h want %h", o, e);
        end
    endtask

    task automatic test_subs_branch();
        snap_t o, e; bit h;
        step(mk(0,1,4'd14,4'b0110,2'b11,0,1,0,0,0), o, e, h);
        checks++;
        if (!h || o !== e || o.flags !== 5'b00110) begin errors++; $display("[TB] FAIL subs_flags got %h want %h", o, e); end
        step(mk(0,1,4'd0,4'b0000,2'b00,1,0,0,0,0), o, e, h);
        checks++;
        if (!h || o !== e || o.pc_src !== 1'b1) begin errors++; $display("[TB] FAIL beq_taken got %h want %h", o, e); end
        step(mk(0,1,4'd1,4'b0000,2'b00,1,0,0,0,0), o, e, h);
        checks++;
        if (!h || o !== e || o.pc_src !== 1'b0) begin errors++; $display("[TB] FAIL bne_skip got %h want %h", o, e); end
    endtask

    task automatic test_read_before_write();
        snap_t o, e; bit h;
        step(mk(0,1,4'd14,4'b0000,2'b11,0,0,0,0,0), o, e, h);
        checks++;
        if (!h || o !== e) begin errors++; $display("[TB] FAIL clear_z got %h want %h", o, e); end
        step(mk(0,1,4'd0,4'b0100,2'b11,0,1,0,0,0), o, e, h);
        checks++;
        if (!h || o !== e || o.cond_ex !== 1'b0 || o.flags[3:0] !== 4'b0000) begin
            errors++; $display("[TB] FAIL rbw_skip got %h want %h", o, e);
        end
    endtask

    task automatic test_nv_nowrite();
        snap_t o, e; bit h;
        step(mk(0,1,4'd15,4'b0000,2'b00,0,0,1,0,0), o, e, h);
        checks++;
        if (!h || o !== e || o.mem_write !== 1'b0) begin errors++; $display("[TB] FAIL nv_mem got %h want %h", o, e); end
        step(mk(0,1,4'd14,4'b0000,2'b00,0,1,0,1,0), o, e, h);
        checks++;
        if (!h || o !== e || o.reg_write !== 1'b0 || o.cond_ex !== 1'b1) begin
            errors++; $display("[TB] FAIL no_write got %h want %h", o, e);
        end
    endtask

    task automatic test_invalid();
        snap_t o, e; bit h;
        step(mk(0,1,4'd14,4'b1010,2'b11,0,0,0,0,0), o, e, h);
        step(mk(0,0,4'd14,4'b0101,2'b11,1,1,1,0,1), o, e, h);
        checks++;
        if (!h || o !== e || o.cond_ex !== 1'b0 || o.flags[3:0] !== 4'b1010) begin
            errors++; $display("[TB] FAIL invalid_hold got %h want %h", o, e);
        end
    endtask

    task automatic test_all_conds();
        snap_t o, e; bit h;
        for (int f = 0; f < 16; f++) begin
            step(mk(0,1,4'd14,4'(f),2'b11,0,0,0,0,0), o, e, h);
            checks++;
            if (!h || o !== e) begin errors++; $display("[TB] FAIL set_flags f=%0d got %h want %h", f, o, e); end
            for (int c = 0; c < 16; c++) begin
                step(mk(0,1,4'(c),4'b0,2'b00,1,1,1,0,0), o, e, h);
                checks++;
                if (!h || o !== e) begin
                    errors++; $display("[TB] FAIL cond f=%0d c=%0d got %h want %h", f, c, o, e);
                end
            end
        end
    endtask

    task automatic test_sticky_q();
        snap_t o, e; bit h;
        step(mk(1,0,4'd0,4'b0,2'b00,0,0,0,0,0), o, e, h);
        step(mk(0,1,4'd14,4'b0001,2'b01,0,0,0,0,0), o, e, h);
        checks++;
        if (!h || o !== e || o.flags[4] !== Q_ON) begin errors++; $display("[TB] FAIL q_set got %h want %h", o, e); end
        step(mk(0,1,4'd14,4'b0000,2'b01,0,0,0,0,0), o, e, h);
        checks++;
        if (!h || o !== e || o.flags[4] !== Q_ON) begin errors++; $display("[TB] FAIL q_sticky got %h want %h", o, e); end
        step(mk(0,1,4'd15,4'b0000,2'b00,0,0,0,0,1), o, e, h);
        checks++;
        if (!h || o !== e || o.flags[4] !== 1'b0) begin errors++; $display("[TB] FAIL q_clear got %h want %h", o, e); end
        step(mk(0,1,4'd14,4'b0001,2'b01,0,0,0,0,1), o, e, h);
        checks++;
        if (!h || o !== e || o.flags[4] !== Q_ON) begin errors++; $display("[TB] FAIL q_set_wins got %h want %h", o, e); end
    endtask

    task automatic test_wrap_and_reset();
        snap_t o, e; bit h;
        step(mk(1,0,4'd0,4'b0,2'b00,0,0,0,0,0), o, e, h);
        for (int i = 0; i < 16; i++) begin
            step(mk(0,1,4'd14,4'b0,2'b00,0,1,0,0,0), o, e, h);
            checks++;
            if (!h || o !== e) begin errors++; $display("[TB] FAIL wrap i=%0d got %h want %h", i, o, e); end
        end
        checks++;
        if (o.exec !== 4'd0) begin errors++; $display("[TB] FAIL wrap_zero got %0d want 0", o.exec); end
        for (int i = 0; i < 3; i++) begin
            step(mk(0,1,4'd15,4'b0,2'b00,0,0,0,0,0), o, e, h);
            checks++;
            if (!h || o !== e) begin errors++; $display("[TB] FAIL skips i=%0d got %h want %h", i, o, e); end
        end
        step(mk(0,1,4'd14,4'b0,2'b00,0,0,0,0,0), o, e, h);
        step(mk(1,1,4'd14,4'b1111,2'b11,0,0,0,0,0), o, e, h);
        checks++;
        if (!h || o !== e || o.exec !== '0 || o.skip !== '0 || o.flags !== 5'b0) begin
            errors++; $display("[TB] FAIL mid_reset got %h want %h", o, e);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        m_flags = 5'b0; m_exec = '0; m_skip = '0;
        rst = 1'b1; instr_valid = 1'b0; cond = 4'd0; alu_flags = 4'd0; flag_write = 2'b00;
        pc_s = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0; q_clear = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_al_write();
        test_subs_branch();
        test_read_before_write();
        test_nv_nowrite();
        test_invalid();
        test_all_conds();
        test_sticky_q();
        test_wrap_and_reset();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_left got %0d want 0", sb_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_logic.md
# cond_logic

Conditional-execution unit for the single-cycle ARM-subset processor. It sits between the instruction decoder and the datapath. It holds the architectural NZCV status register, evaluates each instruction's 4-bit condition field against the stored flags, and gates the decoder's raw write and branch requests. Its `flags` output feeds back to the decoder as the `flags[4:0]` input, so it is the producer end of that interface. It also keeps executed/skipped instruction counters for debug.

## Interface
Parameters:
- `CNT_W`, default 16: width of the executed and skipped counters.

Ports:
- `clk`  in  1  processor clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  the current cycle holds a real instruction; when low, nothing updates and all gated outputs are 0.
- `cond`  in  4  instruction condition field, bits [31:28].
- `alu_flags`  in  4  ALU result flags {N,Z,C,V}.
- `flag_write`  in  2  raw flag-update request: [1] updates N,Z; [0] updates C,V.
- `pc_s`  in  1  raw PC-write/branch request from the decoder.
- `reg_w`  in  1  raw register-write request.
- `mem_w`  in  1  raw memory-write request.
- `no_write`  in  1  compare-class instruction: suppresses `reg_write` even when the condition passes.
- `q_clear`  in  1  clears the sticky-overflow flag (see Configuration).
- `flags`  out  5  registered status {Q,N,Z,C,V}; Q is bit 4.
- `cond_ex`  out  1  condition passed and `instr_valid` is high.
- `pc_src`  out  1  equals `pc_s & cond_ex`.
- `reg_write`  out  1  equals `reg_w & cond_ex & ~no_write`.
- `mem_write`  out  1  equals `mem_w & cond_ex`.
- `exec_count`  out  `CNT_W`  number of valid instructions whose condition passed.
- `skip_count`  out  `CNT_W`  number of valid instructions whose condition failed.

## Operation
Conditions are evaluated from the registered flags N,Z,C,V:
- 0 EQ: Z. 1 NE: !Z.
- 2 CS: C. 3 CC: !C.
- 4 MI: N. 5 PL: !N.
- 6 VS: V. 7 VC: !V.
- 8 HI: C&!Z. 9 LS: !C|Z.
- 10 GE: N==V. 11 LT: N!=V.
- 12 GT: !Z&(N==V). 13 LE: Z|(N!=V).
- 14 AL: 1. 15 NV: 0. NV is treated as never executed and counts as skipped.

Flag update rules:
- N,Z load from `alu_flags[3:2]` when `cond_ex & flag_write[1]`.
- C,V load from `alu_flags[1:0]` when `cond_ex & flag_write[0]`.
- Flags not selected for update hold their value.

Counter rules:
- `exec_count` increments when `instr_valid & cond_ex`.
- `skip_count` increments when `instr_valid & ~cond_ex`.
- Both wrap modulo 2^`CNT_W` with no saturation.

Gated outputs (`cond_ex`, `pc_src`, `reg_write`, `mem_write`) are purely combinational from the current inputs and the registered flags.

## Timing
- Reset: `flags`=5'b0, `exec_count`=0, `skip_count`=0 on the first clock edge with `rst`=1. With flags cleared, gated outputs follow the all-zero flags combinationally (EQ fails, NE passes).
- Condition latency is zero cycles. Flag-write latency is one cycle: the new flags are visible the cycle after the writing instruction.
- Read before write: an instruction that both tests and sets flags is evaluated against the old flags.
- `rst` asserted mid-stream overrides any flag write or counter increment in that cycle.
- When `instr_valid`=0: flags hold, counters hold, `cond_ex`=0.

## Configuration
Macro: `COND_STICKY_Q_EN`.
- Defined: Q (`flags[4]`) is set on any cycle where `cond_ex & flag_write[0] & alu_flags[0]`. It is cleared only by `rst` or by `q_clear`. If set and `q_clear` occur in the same cycle, set wins.
- Undefined: `flags[4]` is tied to 0 and `q_clear` is ignored. The port list is unchanged.

## Structure
- Shared package `cond_pkg` holds:
  - `cond_t` enum covering the 16 codes;
  - flag bit-index localparams `FLG_Q=4`, `FLG_N=3`, `FLG_Z=2`, `FLG_C=1`, `FLG_V=0`.
- One combinational sub-module, `cond_check` (`cond`, `nzcv` → `pass`), which the decoder will also reuse.
- Flag register, Q logic and counters live in `cond_logic`.

## Test plan
- Reset, then `cond`=14 with `reg_w`=1, `instr_valid`=1 → `reg_write`=1, `exec_count`=1, `flags`=0.
- SUBS with `alu_flags`=4'b0110 and `flag_write`=2'b11 → next cycle `flags`=5'b00110. Then BEQ (`cond`=0, `pc_s`=1) → `pc_src`=1. Then BNE → `pc_src`=0, `skip_count` +1.
- Same-cycle `cond`=0, `flag_write`=11, with the Z flag already 0 → instruction skipped and flags unchanged.
- `cond`=15 with `mem_w`=1 → `mem_write`=0 and a skip is counted. `no_write`=1 with `cond`=14 → `reg_write`=0 while `cond_ex`=1.
- With the macro defined: a write with V=1 sets Q=1. A later write with V=0 leaves Q=1. `q_clear` clears it. Without the macro: `flags[4]` stays 0 throughout.
- With `CNT_W`=4: after 16 executed instructions `exec_count`=0. Asserting `rst` mid-run returns both counters to 0 at the next edge.
